// File: rtl/lms_pkg.sv
// Shared fixed-point defaults, FSM state type and sample/weight typedefs for the
// LMS filter datapath (error stage and weight-update stage).
package lms_pkg;

  localparam int unsigned LMS_WIDTH = 16;
  localparam int unsigned LMS_TAPS  = 16;
  localparam int unsigned LMS_FRAC  = 15;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } fir_state_t;

  typedef logic signed [LMS_WIDTH-1:0] sample_t;
  typedef sample_t [LMS_TAPS-1:0]      weight_vec_t;

endpackage

// File: rtl/fx_mac.sv
// Fixed-point multiply-accumulate with round-half-up, width reduction and error
// computation. Define FIR_ERROR_SAT_EN to saturate y/error instead of wrapping.
module fx_mac
  import lms_pkg::*;
#(
  parameter int WIDTH = LMS_WIDTH,
  parameter int TAPS  = LMS_TAPS,
  parameter int FRAC  = LMS_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             mul_en,
  input  logic             acc_en,
  input  logic             round_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] err
);

  localparam int AW = 2*WIDTH + $clog2(TAPS);
  localparam int PW = 2*WIDTH;
  localparam logic signed [AW-1:0] HALF = AW'(64'd1 << (FRAC-1));

  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    yfull;
  logic signed [WIDTH-1:0] ynext;
  logic signed [WIDTH-1:0] enext;
  logic signed [WIDTH:0]   efull;

  assign yfull = (acc + HALF) >>> FRAC;
  assign efull = {d[WIDTH-1], d} - {ynext[WIDTH-1], ynext};

`ifdef FIR_ERROR_SAT_EN
  localparam logic signed [AW-1:0] YMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  always_comb begin
    ynext = WIDTH'(yfull);
    if (yfull > YMAX)      ynext = {1'b0, {(WIDTH-1){1'b1}}};
    else if (yfull < YMIN) ynext = {1'b1, {(WIDTH-1){1'b0}}};
  end

  // A sign/carry disagreement in the extra bit means d - y left the WIDTH range.
  always_comb begin
    enext = WIDTH'(efull);
    if (efull[WIDTH] != efull[WIDTH-1])
      enext = efull[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  always_comb begin
    ynext = WIDTH'(yfull);
    enext = WIDTH'(efull);
  end
`endif

  // Product is registered, so the accumulator trails the multiplier by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      acc  <= '0;
      y    <= '0;
      err  <= '0;
    end else begin
      if (clear) begin
        prod <= '0;
        acc  <= '0;
      end else begin
        if (mul_en) prod <= PW'($signed(a)) * PW'($signed(b));
        if (acc_en) acc  <= acc + AW'(prod);
      end
      if (round_en) begin
        y   <= ynext;
        err <= enext;
      end
    end
  end

endmodule

// File: rtl/fir_error_stage.sv
// FIR error stage: delay line, weight snapshot and sequential MAC producing y and
// d - y for the LMS update stage. FIR_ERROR_SAT_EN selects saturating outputs.
module fir_error_stage
  import lms_pkg::*;
#(
  parameter int WIDTH = LMS_WIDTH,
  parameter int TAPS  = LMS_TAPS,
  parameter int FRAC  = LMS_FRAC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            x_in,
  input  logic [WIDTH-1:0]            d_in,
  input  logic [TAPS-1:0][WIDTH-1:0]  weights,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAPS-1:0][WIDTH-1:0]  taps_out,
  output logic [WIDTH-1:0]            y_out,
  output logic [WIDTH-1:0]            error_out
);

  localparam int CW = $clog2(TAPS+1);
  localparam int IW = $clog2(TAPS);

  fir_state_t state, state_next;

  logic [TAPS-1:0][WIDTH-1:0] taps;
  logic [TAPS-1:0][WIDTH-1:0] wsnap;
  logic [WIDTH-1:0]           d_lat;
  logic [CW-1:0]              idx;
  logic [IW-1:0]              sel;
  logic                       accept;
  logic                       mac_last;
  logic                       mul_en;
  logic                       acc_en;
  logic                       round_en;

  assign accept   = (state == IDLE) && in_valid;
  assign mac_last = (idx == CW'(TAPS));
  assign sel      = idx[IW-1:0];
  assign taps_out = taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (in_valid)  state_next = MAC;
      MAC:   if (mac_last)  state_next = ROUND;
      ROUND:                state_next = OUT;
      OUT:   if (out_ready) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // MAC spans TAPS+1 cycles: TAPS products plus one to drain the product register.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    mul_en    = (state == MAC) && !mac_last;
    acc_en    = (state == MAC) && (idx != '0);
    round_en  = (state == ROUND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps  <= '0;
      wsnap <= '0;
      d_lat <= '0;
      idx   <= '0;
    end else if (accept) begin
      taps  <= {taps[TAPS-2:0], x_in};
      wsnap <= weights;
      d_lat <= d_in;
      idx   <= '0;
    end else if (state == MAC) begin
      idx   <= idx + 1'b1;
    end
  end

  fx_mac #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .FRAC  (FRAC)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .mul_en   (mul_en),
    .acc_en   (acc_en),
    .round_en (round_en),
    .a        (taps[sel]),
    .b        (wsnap[sel]),
    .d        (d_lat),
    .y        (y_out),
    .err      (error_out)
  );

endmodule

// File: tb/tb_fir_error_stage.sv
// Scoreboard bench for fir_error_stage: driver pushes model results at acceptance,
// a negedge monitor compares whenever out_valid is high.
module tb_fir_error_stage;

  localparam int W  = 16;
  localparam int T  = 16;
  localparam int F  = 15;
  localparam int TW = W*T;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [W-1:0]         x_in = '0;
  logic [W-1:0]         d_in = '0;
  logic [T-1:0][W-1:0]  weights = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [T-1:0][W-1:0]  taps_out;
  logic [W-1:0]         y_out;
  logic [W-1:0]         error_out;

  typedef struct {
    logic [W-1:0]  y;
    logic [W-1:0]  e;
    logic [TW-1:0] taps;
    int            edge_no;
  } exp_t;

  exp_t   q[$];
  exp_t   last_exp;
  longint mt[T];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     rand_rdy = 1'b0;
  bit     prev_v = 1'b0;

  fir_error_stage #(
    .WIDTH (W),
    .TAPS  (T),
    .FRAC  (F)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .d_in      (d_in),
    .weights   (weights),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taps_out  (taps_out),
    .y_out     (y_out),
    .error_out (error_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: y = round(sum x[n-i]*w[i] / 2^F), e = d - y, each reduced to W bits.
  function automatic exp_t model_step(input logic [W-1:0] x, input logic [W-1:0] d,
                                      input int edge_no);
    exp_t   ex;
    longint acc = 0;
    longint y;
    longint e;
    longint vmax = (longint'(1) << (W-1)) - 1;
    longint vmin = -(longint'(1) << (W-1));
    for (int i = T-1; i > 0; i--) mt[i] = mt[i-1];
    mt[0] = longint'($signed(x));
    for (int i = 0; i < T; i++) acc += mt[i] * longint'($signed(weights[i]));
    y = (acc + (longint'(1) << (F-1))) >>> F;
`ifdef FIR_ERROR_SAT_EN
    if (y > vmax) y = vmax;
    else if (y < vmin) y = vmin;
`endif
    ex.y = y[W-1:0];
    e = longint'($signed(d)) - longint'($signed(ex.y));
`ifdef FIR_ERROR_SAT_EN
    if (e > vmax) e = vmax;
    else if (e < vmin) e = vmin;
`endif
    ex.e = e[W-1:0];
    for (int i = 0; i < T; i++) ex.taps[i*W +: W] = mt[i][W-1:0];
    ex.edge_no = edge_no;
    last_exp = ex;
    return ex;
  endfunction

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < T; i++) mt[i] = 0;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    x_in = x; d_in = d; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    q.push_back(model_step(x, d, cyc + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid || n > 100) break;
      n++;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: out_valid=1 with no pending result, required 0");
        end else begin
          if (!prev_v) chk("latency", TW'(cyc - q[0].edge_no), TW'(T + 2));
          chk("y_out", TW'(y_out), TW'(q[0].y));
          chk("error_out", TW'(error_out), TW'(q[0].e));
          chk("taps_out", taps_out, q[0].taps);
          chk("in_ready_busy", TW'(in_ready), TW'(0));
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    int n;
    clear_model();
    #1;
    chk("rst_y", TW'(y_out), '0);
    chk("rst_err", TW'(error_out), '0);
    chk("rst_valid", TW'(out_valid), '0);
    chk("rst_taps", taps_out, '0);
    chk("rst_in_ready", TW'(in_ready), TW'(1));
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic result with a single active tap.
    weights = '0;
    weights[0] = 16'h4000;
    send(16'h4000, 16'h3000);
    wait_valid(n);
    chk("basic_latency", TW'(n), TW'(T + 2));
    chk("basic_y", TW'(y_out), TW'(16'h2000));
    chk("basic_err", TW'(error_out), TW'(16'h1000));
    drain();

    // Delay-line ordering from an empty line.
    apply_reset();
    for (int i = 0; i < T; i++) weights[i] = W'($urandom);
    send(16'd1, W'($urandom));
    send(16'd2, W'($urandom));
    send(16'd3, W'($urandom));
    drain();
    for (int i = 0; i < T; i++)
      chk($sformatf("order_tap%0d", i), TW'(taps_out[i]), TW'((i < 3) ? (3 - i) : 0));

    // Full-scale accumulation.
    apply_reset();
    for (int i = 0; i < T; i++) weights[i] = 16'h7FFF;
    repeat (T) send(16'h7FFF, 16'h8000);
    drain();
    chk("ovf_y", TW'(y_out), TW'(last_exp.y));
    chk("ovf_err", TW'(error_out), TW'(last_exp.e));
`ifdef FIR_ERROR_SAT_EN
    chk("ovf_sat_y", TW'(y_out), TW'(16'h7FFF));
    chk("ovf_sat_err", TW'(error_out), TW'(16'h8000));
`endif

    // Backpressure with ignored in_valid pulses while busy.
    out_ready = 1'b0;
    for (int i = 0; i < T; i++) weights[i] = W'($urandom);
    send(W'($urandom), W'($urandom));
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 1) != 0;
      x_in = W'($urandom);
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 1) != 0;
      x_in = W'($urandom);
      weights[0] = W'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("bp_taps_after", taps_out, last_exp.taps);

    // Reset in the middle of the MAC sweep.
    apply_reset();
    for (int i = 0; i < T; i++) weights[i] = W'($urandom);
    send(W'($urandom), W'($urandom));
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("midrst_valid", TW'(out_valid), '0);
    chk("midrst_y", TW'(y_out), '0);
    chk("midrst_err", TW'(error_out), '0);
    chk("midrst_taps", taps_out, '0);
    chk("midrst_in_ready", TW'(in_ready), TW'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(W'($urandom), W'($urandom));
    drain();

    // Random traffic; weights change right after acceptance to test the snapshot.
    rand_rdy = 1'b1;
    repeat (30) begin
      for (int i = 0; i < T; i++) weights[i] = W'($urandom);
      send(W'($urandom), W'($urandom));
      for (int i = 0; i < T; i++) weights[i] = W'($urandom);
    end
    rand_rdy = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
